serial_frame_tx: RTL and testbench
==================================

// Module: serial_frame_tx
// PURPOSE
// - Upstream stage of the serial frame receiver; generates the serIn bit stream that the receiver consumes.
// - Accepts a parallel request (port, count, payload) and serializes it as one frame, MSB first:
//   start bit 0, PORT_W port bits, CNT_W count bits, then count payload bits.
// - Drives the line idle-high between frames and enforces a minimum idle gap.
// PARAMETERS
// - PORT_W    2   destination port field width
// - CNT_W     4   payload length field width; max payload = 2**CNT_W-1 bits
// - DATA_W    15  payload input width; must be >= 2**CNT_W-1
// - IDLE_GAP  1   minimum idle-high cycles after a frame before the next start bit (>=1)
// PORTS
// - clk     in   1       rising-edge clock
// - rst     in   1       asynchronous, active-high reset
// - start   in   1       request; sampled only while ready=1
// - port    in   PORT_W  destination port, latched on accept
// - count   in   CNT_W   payload bit count, latched on accept
// - data    in   DATA_W  payload; bits data[count-1:0] sent, data[count-1] first
// - ready   out  1       1 = IDLE, request accepted on next edge
// - busy    out  1       1 from accept through the end of the idle gap
// - serOut  out  1       serial line; 1 when idle
// - done    out  1       one-cycle pulse after the last frame bit
// BEHAVIOUR
// - Reset (async): state IDLE, serOut=1, ready=1, busy=0, done=0, all counters and shadow regs 0.
// - All outputs are registered. The accept edge (start&ready) latches port, count and data.
//   serOut=0 (start bit) from that same edge, so accept-to-start-bit latency is 1 edge.
// - FSM: IDLE -> START (1 cyc) -> PORT (PORT_W cyc) -> COUNT (CNT_W cyc)
//   -> DATA (count cyc) -> GAP (IDLE_GAP cyc) -> IDLE.
// - count==0: COUNT goes directly to GAP. Frame is 1+PORT_W+CNT_W bits.
// - Bit index counter (width clog2 of the max field) reloads on each state entry and counts down to 0.
//   A state exits on the edge at which index==0.
// - GAP: serOut=1 and busy=1. done=1 for exactly the first GAP cycle.
//   ready=0 throughout GAP and rises on IDLE entry.
// - start while ready=0 is ignored; it is not queued. Input changes after accept have no effect on the frame.
// - start held high continuously: back-to-back frames are separated by exactly IDLE_GAP idle cycles plus 1 IDLE cycle.
// - Reset mid-frame: the line returns to 1 immediately (asynchronous); the partial frame is abandoned, no done pulse.
// - No arithmetic overflow: the index counter never underflows; DATA length is bounded by the CNT_W field.
// STRUCTURE
// - Package serial_frame_pkg:
//   - typedef enum tx_state_t {IDLE, START, PORT, COUNT, DATA, GAP}
//   - localparams for the default PORT_W/CNT_W/DATA_W
//   - start-bit and idle-level constants (START_BIT=0, IDLE_BIT=1); shared with the receiver
// - One natural sub-module, serial_piso_shreg: loadable MSB-first parallel-in/serial-out register.
//   It holds {port,count,data} and shifts one bit per cycle under FSM enable.
//   The FSM plus index counter stays in the top module.
// TESTING
// - Reset idle: rst=1 for 2 cycles, then 5 cycles with no start.
//   -> serOut=1, ready=1, busy=0, done=0 on every cycle.
// - Nominal frame: port=2'b01, count=4'b0110, data=6'b011111.
//   -> serOut = 0,0,1,0,1,1,0,0,1,1,1,1,1 over 13 cycles, then 1.
//   -> done pulses in cycle 14; ready returns at cycle 15.
// - Zero-length frame: port=2'b11, count=0.
//   -> serOut = 0,1,1,0,0,0,0 (7 cycles), then idle; done in cycle 8.
// - Max-length frame: count=4'b1111, data=15'h5555.
//   -> 22 frame bits, payload alternates starting with 1; busy high exactly 23 cycles (IDLE_GAP=1).
// - Ignored request and input change: pulse start at frame bit 5; change data mid-frame.
//   -> current frame bits unchanged, no second frame follows.
// - Async reset at payload bit 3 of a nominal frame.
//   -> serOut=1 before the next edge, no done pulse.
//   -> a new start after release produces a complete correct frame.
// - Optional: feed serOut into the receiver with transmitted=1.
//   -> seroutvalid asserts for the payload on the decoded port.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame transmitter and receiver pair.
package serial_frame_pkg;

  localparam int PORT_W_DEF = 2;
  localparam int CNT_W_DEF  = 4;
  localparam int DATA_W_DEF = 15;

  // Line levels, shared with the receiver so both ends agree on framing
  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    PORT,
    COUNT,
    DATA,
    GAP
  } tx_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_piso_shreg.sv
// Loadable MSB-first parallel-in/serial-out shift register.
module serial_piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg;

  // Load has priority; otherwise shift toward the MSB, filling with zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[W-2:0], 1'b0};
    end
  end

  assign msb = shreg[W-1];

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, port, count, then count payload bits,
// MSB first, followed by a minimum idle-high gap.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int PORT_W   = PORT_W_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PORT_W-1:0] port,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              serOut,
  output logic              done
);

  localparam int SHR_W    = PORT_W + CNT_W + DATA_W;
  localparam int DATA_MAX = (2 ** CNT_W) - 1;
  localparam int IDX_MAX  = max_int(max_int(PORT_W, CNT_W), max_int(DATA_MAX, IDLE_GAP));
  localparam int IDX_W    = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

  localparam logic [IDX_W-1:0] PORT_LAST = IDX_W'(PORT_W - 1);
  localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(CNT_W - 1);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(IDLE_GAP - 1);

  tx_state_t         state;
  tx_state_t         state_n;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_n;
  logic [CNT_W-1:0]  cnt_q;
  logic              load;
  logic              shift;
  logic              piso_msb;
  logic              ser_n;
  logic              done_n;
  logic [DATA_W-1:0] data_aligned;
  logic [SHR_W-1:0]  shr_din;

  // Left-align the payload so data[count-1] follows the count field directly
  assign data_aligned = data << (DATA_W - int'(count));
  assign shr_din      = {port, count, data_aligned};

  serial_piso_shreg #(
    .W(SHR_W)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (shr_din),
    .msb  (piso_msb)
  );

  // Next state, bit index reload/countdown and next line value
  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    shift   = 1'b0;
    ser_n   = IDLE_BIT;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: state_n = PORT;
      PORT: begin
        if (idx == '0) state_n = COUNT;
      end
      COUNT: begin
        if (idx == '0) state_n = (cnt_q == '0) ? GAP : DATA;
      end
      DATA: begin
        if (idx == '0) state_n = GAP;
      end
      GAP: begin
        if (idx == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (state_n != state) begin
      case (state_n)
        PORT:    idx_n = PORT_LAST;
        COUNT:   idx_n = CNT_LAST;
        DATA:    idx_n = IDX_W'(int'(cnt_q) - 1);
        GAP:     idx_n = GAP_LAST;
        default: idx_n = '0;
      endcase
    end else if (idx != '0) begin
      idx_n = idx - 1'b1;
    end

    case (state_n)
      START: ser_n = START_BIT;
      PORT, COUNT, DATA: begin
        ser_n = piso_msb;
        shift = 1'b1;
      end
      default: ser_n = IDLE_BIT;
    endcase

    done_n = (state_n == GAP) && (state != GAP);
  end

  // State and bit index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Shadow copy of the payload length, captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= count;
    end
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serOut <= IDLE_BIT;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      serOut <= ser_n;
      ready  <= (state_n == IDLE);
      busy   <= (state_n != IDLE);
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Randomized scoreboard bench for serial_frame_tx.
module tb_serial_frame_tx;

  localparam int PORT_W   = 2;
  localparam int CNT_W    = 4;
  localparam int DATA_W   = 15;
  localparam int IDLE_GAP = 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [PORT_W-1:0] port;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data;
  logic              ready;
  logic              busy;
  logic              serOut;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Reference model state: edge number, earliest accepting edge, expected frames
  int edge_cnt  = 0;
  int next_free = 0;
  bit exp_bits[$];
  int exp_len[$];
  int exp_edge[$];

  // Monitor state
  int         phase    = 0;
  int         pos      = 0;
  int         cur_len  = 0;
  int         gap_left = 0;
  bit         first_gap;
  logic [3:0] obs;

  serial_frame_tx #(
    .PORT_W  (PORT_W),
    .CNT_W   (CNT_W),
    .DATA_W  (DATA_W),
    .IDLE_GAP(IDLE_GAP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .port  (port),
    .count (count),
    .data  (data),
    .ready (ready),
    .busy  (busy),
    .serOut(serOut),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one request for a single edge; returns during the start-bit cycle
  task automatic applyStimulus(input logic [PORT_W-1:0] p, input logic [CNT_W-1:0] c,
                               input logic [DATA_W-1:0] d);
    @(negedge clk);
    start = 1'b1;
    port  = p;
    count = c;
    data  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait until the model says the next edge would accept a request
  task automatic waitIdle();
    while (edge_cnt + 1 < next_free) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic monitorBit();
    bit eb;
    eb = exp_bits.pop_front();
    checkOutput($sformatf("frame_bit%0d", pos), {28'd0, obs}, {28'd0, eb, 3'b100});
    pos++;
    if (pos == cur_len) begin
      phase     = 2;
      gap_left  = IDLE_GAP;
      first_gap = 1'b1;
    end else begin
      phase = 1;
    end
  endtask

  // Reference model: a request seen at an edge when the link is free becomes a frame
  initial begin
    int len;
    forever begin
      @(posedge clk);
      edge_cnt = edge_cnt + 1;
      if (rst !== 1'b0) begin
        next_free = 0;
      end else if (start === 1'b1 && edge_cnt >= next_free) begin
        len = 1 + PORT_W + CNT_W + int'(count);
        exp_bits.push_back(1'b0);
        for (int i = PORT_W - 1; i >= 0; i--) exp_bits.push_back(port[i]);
        for (int i = CNT_W - 1; i >= 0; i--) exp_bits.push_back(count[i]);
        for (int i = int'(count) - 1; i >= 0; i--) exp_bits.push_back(data[i]);
        exp_len.push_back(len);
        exp_edge.push_back(edge_cnt);
        next_free = edge_cnt + len + IDLE_GAP + 1;
      end
    end
  end

  // Monitor: follows the line and pops expected frames as they appear
  initial begin
    int n;
    forever begin
      @(negedge clk);
      obs = {serOut, busy, ready, done};
      if (rst !== 1'b0) begin
        exp_bits.delete();
        exp_len.delete();
        exp_edge.delete();
        phase = 0;
      end else begin
        case (phase)
          0: begin
            if (exp_edge.size() > 0 && edge_cnt > exp_edge[0]) begin
              checkOutput("frame_start_late", edge_cnt, exp_edge[0]);
              n = exp_len.pop_front();
              void'(exp_edge.pop_front());
              repeat (n) void'(exp_bits.pop_front());
            end
            if (serOut === 1'b0) begin
              if (exp_len.size() == 0) begin
                checkOutput("unexpected_frame", {31'd0, serOut}, 32'd1);
              end else begin
                cur_len = exp_len.pop_front();
                checkOutput("frame_start_edge", edge_cnt, exp_edge.pop_front());
                pos = 0;
                monitorBit();
              end
            end
          end
          1: monitorBit();
          2: begin
            checkOutput("gap_cycle", {28'd0, obs}, {28'd0, 3'b110, first_gap});
            first_gap = 1'b0;
            gap_left--;
            if (gap_left == 0) phase = 3;
          end
          default: begin
            checkOutput("ready_after_gap", {28'd0, obs}, 32'h0000_000A);
            phase = 0;
          end
        endcase
      end
    end
  end

  initial begin
    #500000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [12:0] cap13;
    logic [6:0]  cap7;
    int          bcnt;
    int          zeros;

    rst   = 1'b1;
    start = 1'b0;
    port  = '0;
    count = '0;
    data  = '0;

    $display("[TB] reset idle");
    repeat (2) @(negedge clk);
    checkOutput("in_reset", {28'd0, serOut, ready, busy, done}, 32'hC);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("reset_idle", {28'd0, serOut, ready, busy, done}, 32'hC);
    end

    $display("[TB] nominal frame");
    applyStimulus(2'b01, 4'b0110, DATA_W'(6'b011111));
    cap13 = '0;
    for (int i = 0; i < 13; i++) begin
      cap13 = {cap13[11:0], serOut};
      if (i < 12) @(negedge clk);
    end
    checkOutput("nominal_bits", {19'd0, cap13}, {19'd0, 13'b0010110011111});
    @(negedge clk);
    checkOutput("nominal_done", {30'd0, done, ready}, 32'd2);
    @(negedge clk);
    checkOutput("nominal_ready", {30'd0, done, ready}, 32'd1);

    $display("[TB] zero-length frame");
    waitIdle();
    applyStimulus(2'b11, 4'd0, DATA_W'($urandom));
    cap7 = '0;
    for (int i = 0; i < 7; i++) begin
      cap7 = {cap7[5:0], serOut};
      if (i < 6) @(negedge clk);
    end
    checkOutput("zero_len_bits", {25'd0, cap7}, {25'd0, 7'b0110000});
    @(negedge clk);
    checkOutput("zero_len_done", {30'd0, done, serOut}, 32'd3);

    $display("[TB] max-length frame");
    waitIdle();
    applyStimulus(PORT_W'($urandom), 4'b1111, 15'h5555);
    bcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    checkOutput("max_busy_cycles", bcnt, 32'd23);

    $display("[TB] ignored request");
    waitIdle();
    applyStimulus(2'b10, 4'd5, DATA_W'($urandom));
    repeat (4) @(negedge clk);
    start = 1'b1;
    port  = 2'b01;
    count = CNT_W'($urandom);
    data  = DATA_W'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = DATA_W'($urandom);
      @(negedge clk);
    end
    waitIdle();
    zeros = 0;
    for (int i = 0; i < 10; i++) begin
      if (serOut !== 1'b1) zeros++;
      @(negedge clk);
    end
    checkOutput("no_queued_frame", zeros, 32'd0);

    $display("[TB] reset mid-frame");
    waitIdle();
    applyStimulus(2'b01, 4'd6, DATA_W'(6'b110100));
    repeat (9) @(negedge clk);
    checkOutput("pre_reset_bit", {31'd0, serOut}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_line", {28'd0, serOut, ready, busy, done}, 32'hC);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_done_after_reset", {28'd0, serOut, ready, busy, done}, 32'hC);
    end
    waitIdle();
    applyStimulus(2'b01, 4'd6, DATA_W'(6'b110100));
    cap13 = '0;
    for (int i = 0; i < 13; i++) begin
      cap13 = {cap13[11:0], serOut};
      if (i < 12) @(negedge clk);
    end
    checkOutput("post_reset_bits", {19'd0, cap13}, {19'd0, 13'b0010110110100});

    $display("[TB] back-to-back with start held high");
    waitIdle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start = 1'b1;
      port  = PORT_W'($urandom);
      count = CNT_W'($urandom);
      data  = DATA_W'($urandom);
    end
    @(negedge clk);
    start = 1'b0;

    $display("[TB] random frames");
    for (int i = 0; i < 20; i++) begin
      waitIdle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(PORT_W'($urandom), CNT_W'($urandom), DATA_W'($urandom));
    end

    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", exp_len.size(), 32'd0);
    checkOutput("monitor_idle", phase, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
